// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the 4-digit 7-segment scan controller.
//   scan_state_t : per-slot scan state (BLANK window, then SHOW the digit)
//   SEG_OFF      : all cathodes off (active-low, so all ones)
//   HEX_SEG      : nibble -> {g,f,e,d,c,b,a} active-low segment patterns
//   DIGITS       : number of multiplexed digits
// ---------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam int DIGITS = 4;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index 0 is the rightmost element. Letters use the usual A,b,C,d,E,F shapes.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E,  // F
      7'h06,  // E
      7'h21,  // d
      7'h46,  // C
      7'h03,  // b
      7'h08,  // A
      7'h10,  // 9
      7'h00,  // 8
      7'h78,  // 7
      7'h02,  // 6
      7'h12,  // 5
      7'h19,  // 4
      7'h30,  // 3
      7'h24,  // 2
      7'h79,  // 1
      7'h40   // 0
   };

endpackage

// File: rtl/seg7_hex_decoder.sv
// ---------------------------------------------------------------------------
// seg7_hex_decoder
// Combinational hex nibble to 7-segment decoder, active-low cathodes.
// Ports:
//   nib  in   4  hex digit 0..F
//   seg  out  7  {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_hex_decoder
   import disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nib];

endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed 4-digit 7-segment scan controller. Sits directly upstream
// of the anode decoder: it drives the digit index en and the active-low
// segment / decimal-point cathodes for that digit.
//
// A new value is strobed into a pending register at any time and is copied
// into the displayed (shadow) register only when the scan wraps from digit 3
// back to digit 0, so a frame never shows a mix of old and new digits.
// Each digit slot starts with a forced all-off window to suppress ghosting
// while the anode switches.
//
// Optional build macro:
//   DISP_LZ_BLANK_EN  blank leading zero digits (3..1) whose decimal point is
//                     off; digit 0 is always shown. Undefined: all four
//                     digits are always displayed.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLANK_CYC    forced-blank cycles at slot start (1 <= BLANK_CYC < REFRESH_DIV)
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   synchronous reset, active-low
//   value_in     in   16  four hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        in   4   decimal point per digit, active-high
//   value_valid  in   1   capture strobe for value_in/dp_in
//   en           out  2   current digit index 0..3
//   seg          out  7   cathodes {g,f,e,d,c,b,a}, active-low
//   dp           out  1   decimal-point cathode, active-low
//   frame_done   out  1   one-cycle pulse when pending is committed
// ---------------------------------------------------------------------------
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100_000,
   parameter int unsigned BLANK_CYC   = 1_000
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        value_valid,
   output logic [1:0]  en,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int BLK_W = $clog2(BLANK_CYC + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);

   // prescaler
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   // scan FSM
   scan_state_t      state;
   scan_state_t      state_nxt;
   logic [BLK_W-1:0] blank_cnt;
   logic [BLK_W-1:0] blank_cnt_nxt;
   logic [1:0]       en_nxt;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;

   // value path
   logic [15:0]      pend_val;
   logic [3:0]       pend_dp;
   logic             pend_flag;
   logic [15:0]      shadow_val;
   logic [3:0]       shadow_dp;
   logic             commit;

   // digit decode
   logic [3:0]       cur_nib;
   logic [6:0]       dec_seg;
   logic [3:0]       lz_blank;

   // ------------------------------------------------------------------
   // Slot prescaler: tick marks the last cycle of the current digit slot
   // ------------------------------------------------------------------
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Pending / shadow registers
   // ------------------------------------------------------------------
   // Commit happens on the tick that wraps digit 3 back to digit 0.
   assign commit = tick && (en == 2'd3) && pend_flag;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_flag  <= 1'b0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         frame_done <= 1'b0;
      end else begin
         if (value_valid) begin
            pend_val <= value_in;
            pend_dp  <= dp_in;
         end
         // shadow takes the pending contents as they were before this edge,
         // so a coincident strobe is held over for the next frame
         if (commit) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
         end
         if (value_valid) begin
            pend_flag <= 1'b1;
         end else if (commit) begin
            pend_flag <= 1'b0;
         end
         frame_done <= commit;
      end
   end

   // ------------------------------------------------------------------
   // Digit selection and decode
   // ------------------------------------------------------------------
   assign cur_nib = shadow_val[{en, 2'b00} +: 4];

   seg7_hex_decoder u_dec (
      .nib (cur_nib),
      .seg (dec_seg)
   );

   // A digit is a leading zero when it and every digit to its left are 0;
   // a lit decimal point keeps the digit visible.
   always_comb begin
      lz_blank = '0;
`ifdef DISP_LZ_BLANK_EN
      lz_blank[3] = (shadow_val[15:12] == 4'h0)  && !shadow_dp[3];
      lz_blank[2] = (shadow_val[15:8]  == 8'h00) && !shadow_dp[2];
      lz_blank[1] = (shadow_val[15:4]  == 12'h0) && !shadow_dp[1];
`endif
   end

   // ------------------------------------------------------------------
   // Scan FSM: state register and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= BLANK;
         blank_cnt <= '0;
         en        <= 2'd0;
         seg       <= SEG_OFF;
         dp        <= 1'b1;
      end else begin
         state     <= state_nxt;
         blank_cnt <= blank_cnt_nxt;
         en        <= en_nxt;
         seg       <= seg_nxt;
         dp        <= dp_nxt;
      end
   end

   // Next state and next output values. The outputs are computed from the
   // next state so seg/dp change on the same edge as state/en.
   always_comb begin
      state_nxt     = state;
      blank_cnt_nxt = blank_cnt;
      en_nxt        = en;
      seg_nxt       = SEG_OFF;
      dp_nxt        = 1'b1;

      if (tick) begin
         en_nxt        = en + 2'd1;
         state_nxt     = BLANK;
         blank_cnt_nxt = '0;
      end else begin
         case (state)
            BLANK: begin
               blank_cnt_nxt = blank_cnt + 1'b1;
               if (blank_cnt == BLK_LAST) begin
                  state_nxt = SHOW;
               end
            end
            SHOW: begin
               state_nxt = SHOW;
            end
         endcase
      end

      // SHOW is only entered without a tick, so en_nxt equals en here
      if ((state_nxt == SHOW) && !lz_blank[en]) begin
         seg_nxt = dec_seg;
         dp_nxt  = ~shadow_dp[en];
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// After reset release (cyc=0) the slot phase is cyc%8: phases 0,1 are the
// blank window, phases 2..7 show digit (cyc/8)%4. A commit lands on the edge
// where cyc is a multiple of 32.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value_in = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        value_valid = 1'b0;
   logic [1:0]  en;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          fd_at = -1;
   logic [6:0]  exp_seg [4];
   logic        exp_dp  [4];

   display_scan_ctrl #(
      .REFRESH_DIV (8),
      .BLANK_CYC   (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_in    (value_in),
      .dp_in       (dp_in),
      .value_valid (value_valid),
      .en          (en),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, expv);
   endtask

   // expected shown patterns, digit 3 first; dpc = dp cathodes {d3,d2,d1,d0}
   task automatic set_disp(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input logic [3:0] dpc);
      exp_seg[3] = s3;
      exp_seg[2] = s2;
      exp_seg[1] = s1;
      exp_seg[0] = s0;
      for (int i = 0; i < 4; i++) exp_dp[i] = dpc[i];
   endtask

   // advance n cycles, checking en/seg/dp/frame_done after every edge
   task automatic chk_run(input int n);
      int slot;
      int ph;
      for (int i = 0; i < n; i++) begin
         step();
         slot = (cyc / 8) % 4;
         ph   = cyc % 8;
         check("en", 16'(en), 16'(slot));
         if (ph < 2) begin
            check("seg_blank", 16'(seg), 16'h007F);
            check("dp_blank", 16'(dp), 16'h0001);
         end else begin
            check("seg_show", 16'(seg), 16'(exp_seg[slot]));
            check("dp_show", 16'(dp), 16'(exp_dp[slot]));
         end
         check("frame_done", 16'(frame_done), 16'(cyc == fd_at));
      end
   endtask

   initial begin
      // power-up reset, then run past one commit and leave a pending value
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      value_in = 16'h5555;
      dp_in = 4'hF;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      repeat (44) step();
      value_in = 16'h7777;
      dp_in = 4'h0;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      repeat (5) step();

      // reset mid-scan for 3 cycles
      rst_n = 1'b0;
      step();
      check("rst_en", 16'(en), 16'h0000);
      check("rst_seg", 16'(seg), 16'h007F);
      check("rst_dp", 16'(dp), 16'h0001);
      check("rst_frame_done", 16'(frame_done), 16'h0000);
      step();
      step();
      check("rst_en3", 16'(en), 16'h0000);
      check("rst_seg3", 16'(seg), 16'h007F);
      check("rst_dp3", 16'(dp), 16'h0001);
      check("rst_frame_done3", 16'(frame_done), 16'h0000);
      rst_n = 1'b1;
      cyc = 0;

      // cleared shadow and pending: zeros shown, no commit at the first wrap
`ifdef DISP_LZ_BLANK_EN
      set_disp(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF);
`else
      set_disp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
`endif
      fd_at = -1;
      chk_run(33);

      // 0x1234 committed at the wrap at cyc 64
      value_in = 16'h1234;
      dp_in = 4'h0;
      value_valid = 1'b1;
      chk_run(1);
      value_valid = 1'b0;
      chk_run(29);
      set_disp(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4'hF);
      fd_at = 64;
      chk_run(32);

      // two strobes in one frame: last one wins
      chk_run(3);
      value_in = 16'hAAAA;
      value_valid = 1'b1;
      chk_run(1);
      value_in = 16'h00F0;
      chk_run(1);
      value_valid = 1'b0;
      chk_run(27);
`ifdef DISP_LZ_BLANK_EN
      set_disp(7'h7F, 7'h7F, 7'b0001110, 7'b1000000, 4'hF);
`else
      set_disp(7'b1000000, 7'b1000000, 7'b0001110, 7'b1000000, 4'hF);
`endif
      fd_at = 128;
      chk_run(4);

      // 0x0000 with dp on digit 2, then a strobe coincident with its commit
      value_in = 16'h0000;
      dp_in = 4'b0100;
      value_valid = 1'b1;
      chk_run(1);
      value_valid = 1'b0;
      chk_run(27);
`ifdef DISP_LZ_BLANK_EN
      set_disp(7'h7F, 7'h40, 7'h7F, 7'h40, 4'b1011);
`else
      set_disp(7'h40, 7'h40, 7'h40, 7'h40, 4'b1011);
`endif
      fd_at = 160;
      value_in = 16'hC0DE;
      dp_in = 4'h0;
      value_valid = 1'b1;
      chk_run(1);
      value_valid = 1'b0;
      chk_run(31);

      // held-over value committed one frame later
      set_disp(7'h46, 7'h40, 7'h21, 7'h06, 4'hF);
      fd_at = 192;
      chk_run(32);

      // nothing pending: no pulse at the next wrap
      fd_at = -1;
      chk_run(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
